// File: rtl/cpu_pkg.sv
// Shared encodings for the RV32I multicycle control path: opcodes, FSM states, mux selects.
// The datapath muxes import the same enums so the select encodings stay in one place.
package cpu_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_HALT    = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_IMM   = 2'd1,
      PC_ALU   = 2'd2
   } pc_src_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_JAL,
      CLS_JALR,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_OTHER
   } op_class_e;

   function automatic op_class_e op_class(input logic [6:0] opcode);
      op_class_e cls;
      case (opcode)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls = CLS_ALU;
         OPC_JAL:    cls = CLS_JAL;
         OPC_JALR:   cls = CLS_JALR;
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE:  cls = CLS_STORE;
         OPC_BRANCH: cls = CLS_BRANCH;
         default:    cls = CLS_OTHER;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: funct3 plus the rs1/rs2 comparator flags give taken/not-taken.
// Purely combinational; funct3 010/011 are never taken.
module branch_cond (
   input  logic [2:0] i_funct3,
   input  logic       i_br_eq,
   input  logic       i_br_lt,
   input  logic       i_br_ltu,
   output logic       o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_funct3)
         3'b000:  o_taken = i_br_eq;
         3'b001:  o_taken = ~i_br_eq;
         3'b100:  o_taken = i_br_lt;
         3'b101:  o_taken = ~i_br_lt;
         3'b110:  o_taken = i_br_ltu;
         3'b111:  o_taken = ~i_br_ltu;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/wb, PC enable and next-PC select, stall timeout.
// Optional PC_SEQ_ILLEGAL_HALT_EN: unknown/SYSTEM opcodes park the FSM in HALT until reset.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_br_eq,
   input  logic       i_br_lt,
   input  logic       i_br_ltu,
   input  logic       i_mem_ready,
   output logic       o_mem_req,
   output logic       o_mem_we,
   output logic       o_mem_sel,
   output logic       o_ir_we,
   output logic       o_pc_we,
   output logic [1:0] o_pc_src,
   output logic       o_rf_we,
   output logic [1:0] o_wb_sel,
   output logic [2:0] o_state,
   output logic       o_mem_err
);

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   state_e     r_state;
   logic [7:0] r_stall_cnt;
   logic       r_mem_err;

   state_e     w_next;
   op_class_e  w_cls;
   logic       w_taken;
   logic       w_mem_req, w_mem_we, w_mem_sel, w_ir_we, w_pc_we, w_rf_we;
   pc_src_e    w_pc_src;
   wb_sel_e    w_wb_sel;
   logic       w_stall;
   logic [7:0] w_cnt_next;

   assign w_cls = op_class(i_opcode);

   branch_cond u_branch_cond (
      .i_funct3 (i_funct3),
      .i_br_eq  (i_br_eq),
      .i_br_lt  (i_br_lt),
      .i_br_ltu (i_br_ltu),
      .o_taken  (w_taken)
   );

   always_comb begin
      w_next    = r_state;
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_mem_sel = 1'b0;
      w_ir_we   = 1'b0;
      w_pc_we   = 1'b0;
      w_rf_we   = 1'b0;
      w_pc_src  = PC_PLUS4;
      w_wb_sel  = WB_ALU;
      case (r_state)
         ST_FETCH: begin
            w_mem_req = 1'b1;
            if (i_mem_ready) begin
               w_ir_we = 1'b1;
               w_next  = ST_DECODE;
            end
         end
         ST_DECODE: w_next = ST_EXECUTE;
         ST_EXECUTE: begin
            case (w_cls)
               CLS_ALU, CLS_JAL, CLS_JALR: w_next = ST_WB;
               CLS_LOAD, CLS_STORE:        w_next = ST_MEM;
               CLS_BRANCH: begin
                  w_pc_we  = 1'b1;
                  w_pc_src = w_taken ? PC_IMM : PC_PLUS4;
                  w_next   = ST_FETCH;
               end
               default: begin
`ifdef PC_SEQ_ILLEGAL_HALT_EN
                  w_next = ST_HALT;
`else
                  w_pc_we = 1'b1;
                  w_next  = ST_FETCH;
`endif
               end
            endcase
         end
         ST_MEM: begin
            w_mem_req = 1'b1;
            w_mem_sel = 1'b1;
            w_mem_we  = (w_cls == CLS_STORE);
            if (i_mem_ready) begin
               // Stores retire here; loads still need the writeback cycle.
               if (w_cls == CLS_STORE) begin
                  w_pc_we = 1'b1;
                  w_next  = ST_FETCH;
               end else begin
                  w_next = ST_WB;
               end
            end
         end
         ST_WB: begin
            w_rf_we = 1'b1;
            w_pc_we = 1'b1;
            w_next  = ST_FETCH;
            case (w_cls)
               CLS_LOAD: w_wb_sel = WB_MEM;
               CLS_JAL: begin
                  w_wb_sel = WB_PC4;
                  w_pc_src = PC_IMM;
               end
               CLS_JALR: begin
                  w_wb_sel = WB_PC4;
                  w_pc_src = PC_ALU;
               end
               default: w_wb_sel = WB_ALU;
            endcase
         end
`ifdef PC_SEQ_ILLEGAL_HALT_EN
         ST_HALT: w_next = ST_HALT;
`endif
         default: w_next = ST_FETCH;
      endcase
   end

   // Reset blanks every output at once so an abandoned instruction issues no partial write.
   assign o_mem_req = rst_n & w_mem_req;
   assign o_mem_we  = rst_n & w_mem_we;
   assign o_mem_sel = rst_n & w_mem_sel;
   assign o_ir_we   = rst_n & w_ir_we;
   assign o_pc_we   = rst_n & w_pc_we;
   assign o_rf_we   = rst_n & w_rf_we;
   assign o_pc_src  = rst_n ? w_pc_src : 2'd0;
   assign o_wb_sel  = rst_n ? w_wb_sel : 2'd0;
   assign o_state   = r_state;
   assign o_mem_err = r_mem_err;

   assign w_stall = w_mem_req & ~i_mem_ready;

   always_comb begin
      w_cnt_next = r_stall_cnt;
      if (i_mem_ready)
         w_cnt_next = 8'd0;
      else if (w_stall && (r_stall_cnt < LIMIT))
         w_cnt_next = r_stall_cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_FETCH;
         r_stall_cnt <= 8'd0;
         r_mem_err   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_stall_cnt <= w_cnt_next;
         if (w_cnt_next == LIMIT)
            r_mem_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-instruction cycle traces built from the ISA rules, checked every cycle.
// Directed cases (ADDI, BNE, stalled LW, JALR, fetch timeout, mid-MEM reset) then randomized instruction streams.
module tb_pc_sequencer;

   localparam int LIMIT = 4;

   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_OPIMM  = 7'b0010011;
   localparam logic [6:0] T_AUIPC  = 7'b0010111;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_OP     = 7'b0110011;
   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_SYSTEM = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, mem_err;
   logic [1:0] pc_src, wb_sel;
   logic [2:0] state;

   always #5 clk = ~clk;

   pc_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_opcode(opcode), .i_funct3(funct3),
      .i_br_eq(br_eq), .i_br_lt(br_lt), .i_br_ltu(br_ltu),
      .i_mem_ready(mem_ready),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_sel(mem_sel),
      .o_ir_we(ir_we), .o_pc_we(pc_we), .o_pc_src(pc_src),
      .o_rf_we(rf_we), .o_wb_sel(wb_sel), .o_state(state), .o_mem_err(mem_err)
   );

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       eq, lt, ltu, rdy;
      logic [2:0] st;
      logic       req, we, sel, irwe, pcwe, rfwe, err;
      logic [1:0] pcsrc, wbsel;
   } cyc_t;

   cyc_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   model_run = 0;
   bit   model_err = 1'b0;
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic cur_eq, cur_lt, cur_ltu;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One expected cycle. IR-dependent inputs are only held stable where the FSM is allowed to look at them.
   function void push(input logic [2:0] st, input logic rdy, input logic req, input logic we,
                      input logic sel, input logic irwe, input logic pcwe, input logic [1:0] pcsrc,
                      input logic rfwe, input logic [1:0] wbsel, input bit use_ir);
      cyc_t e;
      e.op  = use_ir ? cur_op  : 7'($urandom);
      e.f3  = use_ir ? cur_f3  : 3'($urandom);
      e.eq  = use_ir ? cur_eq  : rbit();
      e.lt  = use_ir ? cur_lt  : rbit();
      e.ltu = use_ir ? cur_ltu : rbit();
      e.rdy = rdy; e.st = st; e.req = req; e.we = we; e.sel = sel; e.irwe = irwe;
      e.pcwe = pcwe; e.pcsrc = pcsrc; e.rfwe = rfwe; e.wbsel = wbsel;
      e.err = model_err;
      if (rdy) model_run = 0;
      else if (req) begin
         if (model_run < LIMIT) model_run++;
         if (model_run == LIMIT) model_err = 1'b1;
      end
      q.push_back(e);
   endfunction

   function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
      case (f3)
         3'd0: return eq;
         3'd1: return !eq;
         3'd4: return lt;
         3'd5: return !lt;
         3'd6: return ltu;
         3'd7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function void add_instr(input logic [6:0] op, input logic [2:0] f3, input logic eq, input logic lt,
                           input logic ltu, input int fs, input int ds);
      bit is_jal, is_jalr, is_st;
      cur_op = op; cur_f3 = f3; cur_eq = eq; cur_lt = lt; cur_ltu = ltu;
      is_jal = (op == T_JAL); is_jalr = (op == T_JALR); is_st = (op == T_STORE);
      for (int i = 0; i < fs; i++) push(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      push(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      push(3'd1, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      if (op inside {T_OP, T_OPIMM, T_LUI, T_AUIPC, T_JAL, T_JALR}) begin
         push(3'd2, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
         push(3'd4, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0), 1'b1,
              (is_jal || is_jalr) ? 2'd2 : 2'd0, 1'b1);
      end else if (op == T_LOAD || is_st) begin
         push(3'd2, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
         for (int i = 0; i < ds; i++) push(3'd3, 1'b0, 1'b1, is_st, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
         push(3'd3, 1'b1, 1'b1, is_st, 1'b1, 1'b0, is_st, 2'd0, 1'b0, 2'd0, 1'b1);
         if (!is_st) push(3'd4, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1);
      end else if (op == T_BRANCH) begin
         push(3'd2, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              taken_of(f3, eq, lt, ltu) ? 2'd1 : 2'd0, 1'b0, 2'd0, 1'b1);
      end else begin
         push(3'd2, rbit(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1);
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
      end
   endtask

   // Called at a falling edge: drive the cycle's inputs, let them settle, compare, move to next falling edge.
   task automatic run_cycles(input int n);
      cyc_t e;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         e = q.pop_front();
         opcode = e.op; funct3 = e.f3; br_eq = e.eq; br_lt = e.lt; br_ltu = e.ltu; mem_ready = e.rdy;
         #1;
         chk("state", 32'(state), 32'(e.st));
         chk("mem_req", 32'(mem_req), 32'(e.req));
         chk("mem_we", 32'(mem_we), 32'(e.we));
         chk("ir_we", 32'(ir_we), 32'(e.irwe));
         chk("pc_we", 32'(pc_we), 32'(e.pcwe));
         chk("rf_we", 32'(rf_we), 32'(e.rfwe));
         chk("mem_err", 32'(mem_err), 32'(e.err));
         if (e.req)  chk("mem_sel", 32'(mem_sel), 32'(e.sel));
         if (e.pcwe) chk("pc_src", 32'(pc_src), 32'(e.pcsrc));
         if (e.rfwe) chk("wb_sel", 32'(wb_sel), 32'(e.wbsel));
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_all();
      run_cycles(1000);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      q.delete();
      model_run = 0;
      model_err = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_pc_we", 32'(pc_we), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_ir_we", 32'(ir_we), 32'd0);
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [6:0] op_tab [11];

   initial begin
      op_tab = '{T_LOAD, T_OPIMM, T_AUIPC, T_STORE, T_OP, T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYSTEM, 7'b0001111};
      @(negedge clk);
      do_reset();

      add_instr(T_OPIMM, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("addi_len", 32'(q.size()), 32'd4);
      run_all();
      add_instr(T_BRANCH, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("bne_len", 32'(q.size()), 32'd3);
      add_instr(T_BRANCH, 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);
      run_all();
      add_instr(T_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      chk("lw_stall_len", 32'(q.size()), 32'd8);
      run_all();
      add_instr(T_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_all();
      chk("no_err_yet", 32'(mem_err), 32'd0);
      add_instr(T_OP, 3'd0, 1'b0, 1'b0, 1'b0, 6, 0);
      chk("fetch_stall_len", 32'(q.size()), 32'd10);
      run_all();
      chk("err_sticky", 32'(mem_err), 32'd1);
      add_instr(T_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("sw_len", 32'(q.size()), 32'd4);
      run_all();
      add_instr(T_SYSTEM, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("system_nop_len", 32'(q.size()), 32'd3);
      run_all();

      // Abandon a load part-way through its data phase.
      add_instr(T_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 10);
      run_cycles(5);
      do_reset();
      add_instr(T_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_all();

      for (int n = 0; n < 250; n++) begin
         int fs, ds;
         logic [6:0] op;
         op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 10)];
         fs = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
         ds = ($urandom_range(0, 15) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
         add_instr(op, 3'($urandom), rbit(), rbit(), rbit(), fs, ds);
         run_all();
         if (n == 125) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle control FSM for the RV32I core. It sequences the program counter, instruction register, unified memory port and register-file writeback. Every instruction passes through fetch, decode, execute and optional memory and writeback states. The block drives the program counter's `increment_en` through `pc_we` and selects the next-PC source, so the PC register stays a plain enabled register with no branch logic of its own.

## Interface
- `WAIT_LIMIT`, default 15: consecutive memory-stall cycles before `mem_err` is raised; range 1–255.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  IR[6:0].
- `funct3`  in  3  IR[14:12].
- `br_eq`, `br_lt`, `br_ltu`  in  1 each  comparator flags for rs1 vs rs2.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  the request is a store.
- `mem_sel`  out  1  address select: 0 = PC (fetch), 1 = ALU result (data).
- `ir_we`  out  1  latch read data into IR.
- `pc_we`  out  1  PC register enable.
- `pc_src`  out  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = {alu[31:1],1'b0}.
- `rf_we`  out  1  register-file write enable.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory data, 2 = PC+4.
- `state`  out  3  current state, for debug.
- `mem_err`  out  1  sticky memory-timeout flag.

## Operation
- **States:** FETCH, DECODE, EXECUTE, MEM, WB, plus HALT when configured.
- **FETCH:** `mem_req`=1, `mem_sel`=0. When `mem_ready`=1, assert `ir_we`=1 in the same cycle and go to DECODE. Otherwise stay in FETCH.
- **DECODE:** one cycle with no enables asserted, then EXECUTE.
- **EXECUTE, by opcode:**
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR → WB.
  - LOAD, STORE → MEM.
  - BRANCH → `pc_we`=1, `pc_src`=taken ? 1 : 0, then FETCH.
  - Any other opcode → `pc_we`=1, `pc_src`=0, then FETCH (NOP).
- **Branch taken, by funct3:**
  - 000 = eq; 001 = !eq.
  - 100 = lt; 101 = !lt.
  - 110 = ltu; 111 = !ltu.
  - 010 and 011 are never taken.
- **MEM:** `mem_req`=1, `mem_sel`=1, `mem_we`=1 for STORE. On `mem_ready`:
  - STORE → `pc_we`=1, `pc_src`=0, then FETCH.
  - LOAD → WB.
- **WB:** `rf_we`=1 and `pc_we`=1, then FETCH.
  - `wb_sel`: LOAD = 1, JAL/JALR = 2, otherwise 0.
  - `pc_src`: JAL = 1, JALR = 2, otherwise 0.
- **Opcode sampling:** `opcode` and `funct3` are sampled only in EXECUTE, MEM and WB. The IR is stable in those states.
- **Stall timer:** an 8-bit counter increments on each cycle with `mem_req`=1 and `mem_ready`=0, and clears whenever `mem_ready`=1.
  - When the count reaches `WAIT_LIMIT`, `mem_err` sets. It is sticky until reset.
  - The FSM keeps waiting regardless; `mem_err` has no effect on sequencing.
- **Exclusivity:** `pc_we` is asserted for exactly one cycle per instruction.

## Timing
- **Reset:** while `rst_n`=0, state is FETCH, the stall counter is 0, `mem_err`=0 and all registered outputs are 0.
  - The first cycle after deassertion is FETCH with `mem_req`=1.
  - Reset asserted mid-instruction abandons it immediately. No partial `pc_we` or `rf_we` is issued.
- **Output types:** `ir_we` and the MEM-state `pc_we` are Mealy outputs, gated combinationally by `mem_ready`. All other outputs are Moore, decoded from state and opcode.
- **Latency with zero-wait memory:**
  - ALU and jump instructions: 4 cycles (F, D, E, W).
  - Branches: 3 cycles.
  - Stores: 4 cycles.
  - Loads: 5 cycles.
  - Each stall cycle adds 1.
- **Handshake:** `mem_req`, `mem_sel` and `mem_we` stay constant from the first request cycle until the `mem_ready` cycle inclusive. `mem_ready` outside FETCH or MEM is ignored.
- **Stall counter saturation:** the counter saturates at `WAIT_LIMIT` and does not wrap.

## Configuration
- **Macro:** `PC_SEQ_ILLEGAL_HALT_EN`.
- **Defined:**
  - In EXECUTE, an unknown opcode or SYSTEM (7'b1110011) → HALT.
  - In HALT, all enables and `mem_req` are 0 and `state`=5, until reset.
- **Undefined:** HALT does not exist, and those opcodes execute as NOPs as described above.

## Structure
- **Shared package `cpu_pkg`:** opcode localparams, the state enum, and the `pc_src_e` and `wb_sel_e` enums. The datapath muxes import the same encodings.
- **Sub-module `branch_cond`:** combinational; `funct3` plus the three flags → taken.

## Test plan
- **ADDI, zero wait:** FETCH→DECODE→EXECUTE→WB. `rf_we`=1, `wb_sel`=0, `pc_we`=1, `pc_src`=0 in cycle 4. `mem_req` asserted again in cycle 5.
- **BNE with `br_eq`=0, then with `br_eq`=1:** in the EXECUTE cycle, `pc_we`=1 with `pc_src`=1 for the first and `pc_src`=0 for the second. No `rf_we`.
- **LW with `mem_ready` low for 3 data cycles:** MEM is held 4 cycles with stable `mem_sel`=1 and `mem_we`=0. Then WB with `wb_sel`=1. Total 8 cycles.
- **JALR:** WB asserts `rf_we`=1, `wb_sel`=2 and `pc_src`=2.
- **Fetch stall with `WAIT_LIMIT`=4:** `mem_ready` held low for 6 cycles. `mem_err` rises after the 4th stall cycle and stays 1 after the fetch completes.
- **Reset and SYSTEM opcode:**
  - `rst_n` pulsed low during MEM: outputs are 0 immediately and FETCH follows deassertion.
  - SYSTEM opcode with the macro defined: HALT, with `pc_we` and `mem_req` at 0 for 20 cycles.
